// File: rtl/rst_pkg.sv
// rst_pkg: shared definitions for the reset sequencer.
//   - state_e     : sequencer FSM states (HOLD, RELEASE, RUN)
//   - CAUSE_*     : reset-cause encodings reported when RST_SEQ_CAUSE_EN is defined
//   - cnt_width() : width of the hold/gap/soft-reset counters
package rst_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RELEASE = 2'b01,
        RUN     = 2'b10
    } state_e;

    localparam logic [1:0] CAUSE_RST = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;

    // One extra bit above $clog2 of the largest terminal count so that no
    // counter can wrap before its compare fires.
    function automatic int cnt_width(input int hold, input int gap, input int sw);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (sw > m)  m = sw;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: NUM_STAGES-deep synchroniser bringing the asynchronous
// external reset request into the clk domain.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low block reset, clears every stage to 0
//   din      in  asynchronous input (external reset request, active-low)
//   ext_sync out synchronised copy of din (last stage)
module rst_sync_chain
    import rst_pkg::*;
#(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic ext_sync
);

    logic [NUM_STAGES-1:0] sync_q;
    logic [NUM_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[NUM_STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ext_sync = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer. Synchronises the external active-low reset
// request, holds every domain reset low for HOLD_CYCLES after the request
// clears, then releases channel 0..NUM_CH-1 GAP_CYCLES apart. Once all
// channels are released (RUN) per-channel software resets pulse a channel
// low for SW_LEN cycles after the last request.
// Ports:
//   CLK         in   system clock
//   RST         in   synchronous active-low block reset (highest priority)
//   EXT_RST_N   in   asynchronous active-low external reset request
//   SW_RST_REQ  in   per-channel software reset request (honoured in RUN only)
//   SYNC_RST    out  sequenced active-low resets, bit 0 released first
//   RST_DONE    out  high in RUN
// Optional (macro RST_SEQ_CAUSE_EN):
//   RST_CAUSE   out  CAUSE_RST after RST, CAUSE_EXT after an external re-assert
//   SW_RST_SEEN out  sticky per-channel flag of accepted software requests
module rst_seq
    import rst_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_CH      = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int SW_LEN      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXT_RST_N,
    input  logic [NUM_CH-1:0] SW_RST_REQ,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE
`ifdef RST_SEQ_CAUSE_EN
    ,
    output logic [1:0]        RST_CAUSE,
    output logic [NUM_CH-1:0] SW_RST_SEEN
`endif
);

    localparam int CW    = cnt_width(HOLD_CYCLES, GAP_CYCLES, SW_LEN);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_STAGES < 2 || NUM_STAGES > 4 || NUM_CH < 1 || NUM_CH > 8 ||
        HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SW_LEN < 1) begin : g_param_check
        $error("rst_seq: illegal parameter value");
    end

    logic ext_sync;

    rst_sync_chain #(
        .NUM_STAGES(NUM_STAGES)
    ) u_sync (
        .clk      (CLK),
        .rst_n    (RST),
        .din      (EXT_RST_N),
        .ext_sync (ext_sync)
    );

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_CH-1:0]          sync_rst_q, sync_rst_d;
    logic                       done_q, done_d;
    logic [NUM_CH-1:0][CW-1:0]  sw_cnt_q, sw_cnt_d;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0]                 cause_q, cause_d;
    logic [NUM_CH-1:0]          seen_q, seen_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync_rst_d = sync_rst_q;
        done_d     = done_q;
        sw_cnt_d   = sw_cnt_q;
`ifdef RST_SEQ_CAUSE_EN
        cause_d    = cause_q;
        seen_d     = seen_q;
`endif
        if (!ext_sync) begin
            // External request wins over everything, including soft requests.
            state_d    = HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            sync_rst_d = '0;
            done_d     = 1'b0;
            sw_cnt_d   = '0;
`ifdef RST_SEQ_CAUSE_EN
            // HOLD with an idle counter is where RST leaves us while the
            // synchroniser refills; only a low after a high counts as a
            // genuine external re-assert.
            if (state_q != HOLD || cnt_q != '0) begin
                cause_d = CAUSE_EXT;
            end
            seen_d = '0;
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        sync_rst_d[0] = 1'b1;
                        cnt_d         = '0;
                        if (NUM_CH == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        sync_rst_d[idx_q] = 1'b1;
                        cnt_d             = '0;
                        if (idx_q == IDX_W'(NUM_CH - 1)) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // A low channel in RUN is stretching a soft reset; a new
                    // request reloads the stretch counter.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (SW_RST_REQ[i]) begin
                            sync_rst_d[i] = 1'b0;
                            sw_cnt_d[i]   = CW'(SW_LEN - 1);
`ifdef RST_SEQ_CAUSE_EN
                            seen_d[i]     = 1'b1;
`endif
                        end else if (!sync_rst_q[i]) begin
                            if (sw_cnt_q[i] == '0) begin
                                sync_rst_d[i] = 1'b1;
                            end else begin
                                sw_cnt_d[i] = sw_cnt_q[i] - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d    = HOLD;
                    cnt_d      = '0;
                    idx_d      = '0;
                    sync_rst_d = '0;
                    done_d     = 1'b0;
                    sw_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_q <= '0;
            done_q     <= 1'b0;
            sw_cnt_q   <= '0;
`ifdef RST_SEQ_CAUSE_EN
            cause_q    <= CAUSE_RST;
            seen_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_q <= sync_rst_d;
            done_q     <= done_d;
            sw_cnt_q   <= sw_cnt_d;
`ifdef RST_SEQ_CAUSE_EN
            cause_q    <= cause_d;
            seen_q     <= seen_d;
`endif
        end
    end

    assign SYNC_RST = sync_rst_q;
    assign RST_DONE = done_q;
`ifdef RST_SEQ_CAUSE_EN
    assign RST_CAUSE   = cause_q;
    assign SW_RST_SEEN = seen_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and randomised stimulus for rst_seq with a cycle-level
// reference model built from the release schedule and soft-reset rules.
module tb_rst_seq;

    localparam int NS   = 2;
    localparam int NCH  = 3;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int SWL  = 4;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           EXT_RST_N = 1'b1;
    logic [NCH-1:0] SW_RST_REQ = '0;
    logic [NCH-1:0] SYNC_RST;
    logic           RST_DONE;
`ifdef RST_SEQ_CAUSE_EN
    logic [1:0]     RST_CAUSE;
    logic [NCH-1:0] SW_RST_SEEN;
`endif

    rst_seq #(
        .NUM_STAGES  (NS),
        .NUM_CH      (NCH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .SW_LEN      (SWL)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EXT_RST_N  (EXT_RST_N),
        .SW_RST_REQ (SW_RST_REQ),
        .SYNC_RST   (SYNC_RST),
        .RST_DONE   (RST_DONE)
`ifdef RST_SEQ_CAUSE_EN
        ,
        .RST_CAUSE  (RST_CAUSE),
        .SW_RST_SEEN(SW_RST_SEEN)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit         m_dl[NS];      // external request delay line (synchroniser)
    int         m_high;        // consecutive edges with synchronised request high
    int         m_low[NCH];    // remaining soft-reset low cycles per channel
    bit [NCH-1:0] m_seen = '0;
    bit [1:0]   m_cause = 2'b00;
    bit [NCH-1:0] m_sync = '0;
    bit         m_done = 1'b0;

    function automatic int released(input int h);
        int r;
        if (h < HOLD) return 0;
        r = 1 + (h - HOLD) / GAP;
        if (r > NCH) r = NCH;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit es;
        bit done_prev;
        int n;
        if (!RST) begin
            for (int k = 0; k < NS; k++) m_dl[k] = 1'b0;
            m_high = 0;
            for (int i = 0; i < NCH; i++) m_low[i] = 0;
            m_seen  = '0;
            m_cause = 2'b00;
        end else begin
            es        = m_dl[NS-1];
            done_prev = (released(m_high) == NCH);
            for (int k = NS - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
            m_dl[0] = EXT_RST_N;
            if (!es) begin
                if (m_high > 0) m_cause = 2'b01;
                m_high = 0;
                for (int i = 0; i < NCH; i++) m_low[i] = 0;
                m_seen = '0;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (done_prev && SW_RST_REQ[i]) begin
                        m_low[i]  = SWL;
                        m_seen[i] = 1'b1;
                    end else if (m_low[i] > 0) begin
                        m_low[i]--;
                    end
                end
                if (m_high < 1000000) m_high++;
            end
        end
        n = released(m_high);
        for (int i = 0; i < NCH; i++) m_sync[i] = (i < n) && (m_low[i] == 0);
        m_done = (n == NCH);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        chk("model_sync", 32'(SYNC_RST), 32'(m_sync));
        chk("model_done", 32'(RST_DONE), 32'(m_done));
`ifdef RST_SEQ_CAUSE_EN
        chk("model_cause", 32'(RST_CAUSE), 32'(m_cause));
        chk("model_seen", 32'(SW_RST_SEEN), 32'(m_seen));
`endif
    endtask

    task automatic wait_done();
        for (int j = 0; j < 100 && !RST_DONE; j++) tick();
        chk("wait_done", 32'(RST_DONE), 32'd1);
    endtask

    initial begin
        int k;
        int low;
        int ext_left;
        for (int kk = 0; kk < NS; kk++) m_dl[kk] = 1'b0;
        m_high = 0;
        for (int i = 0; i < NCH; i++) m_low[i] = 0;

        // Reset state.
        tick();
        tick();
        chk("reset_sync", 32'(SYNC_RST), 32'd0);
        chk("reset_done", 32'(RST_DONE), 32'd0);
`ifdef RST_SEQ_CAUSE_EN
        chk("reset_cause", 32'(RST_CAUSE), 32'd0);
        chk("reset_seen", 32'(SW_RST_SEEN), 32'd0);
`endif

        // Release order: edges numbered from the first edge with RST high.
        RST = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 9)  chk("order_e9",  32'(SYNC_RST), 32'b000);
            if (e == 10) chk("order_e10", 32'(SYNC_RST), 32'b001);
            if (e == 13) chk("order_e13", 32'(SYNC_RST), 32'b001);
            if (e == 14) chk("order_e14", 32'(SYNC_RST), 32'b011);
            if (e == 17) chk("order_done17", 32'(RST_DONE), 32'd0);
            if (e == 18) chk("order_e18", 32'(SYNC_RST), 32'b111);
            if (e == 18) chk("order_done18", 32'(RST_DONE), 32'd1);
        end

        // Single soft reset on channel 1.
        low = 0;
        SW_RST_REQ = 3'b010;
        tick();
        SW_RST_REQ = '0;
        for (int j = 0; j < 50; j++) begin
            if (SYNC_RST[1]) break;
            low++;
            chk("soft_others", 32'({SYNC_RST[2], SYNC_RST[0], RST_DONE}), 32'b111);
            tick();
        end
        chk("soft_len", low, SWL);

        // Re-request two cycles later stretches the pulse.
        low = 0;
        SW_RST_REQ = 3'b010;
        tick();
        if (!SYNC_RST[1]) low++;
        SW_RST_REQ = '0;
        tick();
        if (!SYNC_RST[1]) low++;
        SW_RST_REQ = 3'b010;
        tick();
        if (!SYNC_RST[1]) low++;
        SW_RST_REQ = '0;
        for (int j = 0; j < 50; j++) begin
            tick();
            if (SYNC_RST[1]) break;
            low++;
        end
        chk("soft_extend", low, 6);
        chk("soft_done", 32'(RST_DONE), 32'd1);

        // External re-assert in RUN for three cycles.
        EXT_RST_N = 1'b0;
        tick();
        tick();
        tick();
        chk("ext_latency", 32'(SYNC_RST), 32'd0);
        chk("ext_done", 32'(RST_DONE), 32'd0);
`ifdef RST_SEQ_CAUSE_EN
        chk("ext_cause", 32'(RST_CAUSE), 32'd1);
`endif
        EXT_RST_N = 1'b1;
        k = 0;
        while (k < 100) begin
            tick();
            k++;
            if (SYNC_RST[0]) break;
        end
        chk("ext_release", k, NS + HOLD);

        // Interrupt the release right after ch0; soft requests in HOLD/RELEASE ignored.
        EXT_RST_N = 1'b0;
        tick();
        EXT_RST_N = 1'b1;
        SW_RST_REQ = '1;
        tick();
        tick();
        chk("intr_clear", 32'(SYNC_RST), 32'd0);
        k = 2;
        while (k < 100) begin
            tick();
            k++;
            if (SYNC_RST[0]) break;
        end
        chk("intr_release", k, NS + HOLD);
        SW_RST_REQ = '0;
        wait_done();
        chk("intr_all", 32'(SYNC_RST), 32'b111);

        // Soft request held together with an external re-assert.
        SW_RST_REQ = 3'b010;
        EXT_RST_N  = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        SW_RST_REQ = '0;
        EXT_RST_N  = 1'b1;
        chk("simul_sync", 32'(SYNC_RST), 32'd0);
`ifdef RST_SEQ_CAUSE_EN
        chk("simul_seen", 32'(SW_RST_SEEN), 32'd0);
        chk("simul_cause", 32'(RST_CAUSE), 32'd1);
`endif
        wait_done();

        // Randomised traffic checked against the model every cycle.
        ext_left = 0;
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 799) != 0);
            if (ext_left > 0) begin
                EXT_RST_N = 1'b0;
                ext_left--;
            end else if ($urandom_range(0, 79) == 0) begin
                EXT_RST_N = 1'b0;
                ext_left  = $urandom_range(0, 2);
            end else begin
                EXT_RST_N = 1'b1;
            end
            SW_RST_REQ = NCH'($urandom & $urandom & $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
